// File: rtl/fxp_accumulate_64.sv
// Accumulates a framed stream of signed Q32.32 operands into one sum per frame, with overflow flag and optional clamp.
// Latency: the frame result is presented on the cycle after the last-beat accept.
// Backpressure: a result waiting in HOLD keeps in_ready low until out_ready takes it, leaving one bubble per frame.
module fxp_accumulate_64 #(
   parameter int WIDTH    = 64,
   parameter int FRAC     = 32,
   parameter int CNT_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_overflow,
   output logic [CNT_W-1:0] out_count
);

   localparam int MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {MSB{1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {MSB{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // FRAC only names the binary point; the arithmetic is plain two's complement.
   if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_chk
      $error("FRAC must lie in [0, WIDTH)");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             r_ovf;
   logic             w_ovf_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_in_rdy;
   logic             w_in_rdy_nxt;
   logic             r_out_vld;
   logic             w_out_vld_nxt;
   logic [WIDTH-1:0] r_out_dat;
   logic [WIDTH-1:0] w_out_dat_nxt;
   logic             r_out_ovf;
   logic             w_out_ovf_nxt;
   logic [CNT_W-1:0] r_out_cnt;
   logic [CNT_W-1:0] w_out_cnt_nxt;

   logic             w_accept;
   logic [WIDTH-1:0] w_sum;
   logic             w_ov;
   logic [WIDTH-1:0] w_result;
   logic             w_ovf_acc;
   logic [CNT_W-1:0] w_cnt_inc;

   assign in_ready     = r_in_rdy;
   assign out_valid    = r_out_vld;
   assign out_data     = r_out_dat;
   assign out_overflow = r_out_ovf;
   assign out_count    = r_out_cnt;

   // Per-beat arithmetic: full-width add, signed overflow test, optional clamp toward the accumulator's sign.
   always_comb begin
      w_accept  = in_valid & r_in_rdy;
      w_sum     = r_acc + in_data;
      w_ov      = (r_acc[MSB] == in_data[MSB]) & (w_sum[MSB] != r_acc[MSB]);
      w_result  = w_sum;
      if (SATURATE && w_ov) begin
         w_result = r_acc[MSB] ? SAT_MIN : SAT_MAX;
      end
      w_ovf_acc = r_ovf | w_ov;
      w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   end

   // Next-state and next-register decode; everything holds unless a beat is accepted or a result is taken.
   always_comb begin
      w_state_nxt   = r_state;
      w_acc_nxt     = r_acc;
      w_ovf_nxt     = r_ovf;
      w_cnt_nxt     = r_cnt;
      w_out_vld_nxt = r_out_vld;
      w_out_dat_nxt = r_out_dat;
      w_out_ovf_nxt = r_out_ovf;
      w_out_cnt_nxt = r_out_cnt;
      case (r_state)
         IDLE, ACCUM: begin
            if (w_accept) begin
               if (in_last) begin
                  w_out_dat_nxt = w_result;
                  w_out_ovf_nxt = w_ovf_acc;
                  w_out_cnt_nxt = w_cnt_inc;
                  w_out_vld_nxt = 1'b1;
                  w_acc_nxt     = '0;
                  w_ovf_nxt     = 1'b0;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = HOLD;
               end else begin
                  w_acc_nxt   = w_result;
                  w_ovf_nxt   = w_ovf_acc;
                  w_cnt_nxt   = w_cnt_inc;
                  w_state_nxt = ACCUM;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_out_vld_nxt = 1'b0;
               w_state_nxt   = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // Registered from the next state so out_ready never reaches in_ready combinationally.
      w_in_rdy_nxt = (w_state_nxt != HOLD);
   end

   // State and datapath registers; reset discards any partial sum or pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_cnt     <= '0;
         r_in_rdy  <= 1'b0;
         r_out_vld <= 1'b0;
         r_out_dat <= '0;
         r_out_ovf <= 1'b0;
         r_out_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_ovf     <= w_ovf_nxt;
         r_cnt     <= w_cnt_nxt;
         r_in_rdy  <= w_in_rdy_nxt;
         r_out_vld <= w_out_vld_nxt;
         r_out_dat <= w_out_dat_nxt;
         r_out_ovf <= w_out_ovf_nxt;
         r_out_cnt <= w_out_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fxp_accumulate_64.sv
// Bench for fxp_accumulate_64: a clamping and a wrapping instance share one stimulus stream.
// Latency: results are expected on the cycle after the last-beat accept.
// Backpressure: out_ready is held low in one scenario to check HOLD stability and the bubble.
module tb_fxp_accumulate_64;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready_s,  in_ready_w;
   logic        out_valid_s, out_valid_w;
   logic [63:0] out_data_s,  out_data_w;
   logic        out_ovf_s,   out_ovf_w;
   logic [15:0] out_cnt_s,   out_cnt_w;

   typedef struct {
      logic [63:0] d_s;
      logic [63:0] d_w;
      logic        o_s;
      logic        o_w;
      logic [15:0] c;
   } exp_t;

   exp_t sb[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   n_pushed  = 0;
   int   n_results = 0;

   fxp_accumulate_64 #(.WIDTH(64), .FRAC(32), .CNT_W(16), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
      .out_overflow(out_ovf_s), .out_count(out_cnt_s)
   );

   fxp_accumulate_64 #(.WIDTH(64), .FRAC(32), .CNT_W(16), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
      .out_overflow(out_ovf_w), .out_count(out_cnt_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every result that is about to be handshaken is popped and compared.
   always @(negedge clk) begin
      if (rst_n && out_valid_s && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_result out_data=%h (no result expected)", out_data_s);
         end else begin
            exp_t e;
            n_pass++;
            e = sb.pop_front();
            n_results++;
            n_checks++;
            if (out_data_s !== e.d_s) $display("FAIL sat_data got=%h exp=%h", out_data_s, e.d_s);
            else n_pass++;
            n_checks++;
            if (out_ovf_s !== e.o_s) $display("FAIL sat_ovf got=%b exp=%b", out_ovf_s, e.o_s);
            else n_pass++;
            n_checks++;
            if (out_cnt_s !== e.c) $display("FAIL sat_cnt got=%0d exp=%0d", out_cnt_s, e.c);
            else n_pass++;
            n_checks++;
            if (out_valid_w !== 1'b1) $display("FAIL wrap_valid got=%b exp=1", out_valid_w);
            else n_pass++;
            n_checks++;
            if (out_data_w !== e.d_w) $display("FAIL wrap_data got=%h exp=%h", out_data_w, e.d_w);
            else n_pass++;
            n_checks++;
            if (out_ovf_w !== e.o_w) $display("FAIL wrap_ovf got=%b exp=%b", out_ovf_w, e.o_w);
            else n_pass++;
            n_checks++;
            if (out_cnt_w !== e.c) $display("FAIL wrap_cnt got=%0d exp=%0d", out_cnt_w, e.c);
            else n_pass++;
         end
      end
   end

   task automatic push_exp(input logic [63:0] ds, input logic [63:0] dw,
                           input logic os, input logic ow, input logic [15:0] c);
      exp_t e;
      e.d_s = ds; e.d_w = dw; e.o_s = os; e.o_w = ow; e.c = c;
      sb.push_back(e);
      n_pushed++;
   endtask

   // Drive one beat from a negedge; returns at the negedge after the accepting posedge.
   task automatic send_beat(input logic [63:0] d, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!(in_ready_s && in_ready_w) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_checks++;
         $display("FAIL send_timeout in_ready_s=%b in_ready_w=%b exp=1", in_ready_s, in_ready_w);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 'x;
      in_last  = 1'bx;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 'x; in_last = 1'bx; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready_s !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready_s); else n_pass++;
      n_checks++; if (out_valid_s !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid_s); else n_pass++;
      n_checks++; if (out_data_s !== 64'd0) $display("FAIL rst_out_data got=%h exp=0", out_data_s); else n_pass++;
      n_checks++; if (out_cnt_s !== 16'd0) $display("FAIL rst_out_count got=%0d exp=0", out_cnt_s); else n_pass++;
      n_checks++; if (out_ovf_w !== 1'b0) $display("FAIL rst_out_ovf got=%b exp=0", out_ovf_w); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready_s !== 1'b1) $display("FAIL rst_rel_in_ready got=%b exp=1", in_ready_s); else n_pass++;
   endtask

   task automatic test_basic();
      push_exp(64'h0000_0003_0000_0000, 64'h0000_0003_0000_0000, 1'b0, 1'b0, 16'd3);
      send_beat(64'h0000_0001_0000_0000, 1'b0);
      send_beat(64'h0000_0002_8000_0000, 1'b0);
      send_beat(64'hFFFF_FFFF_8000_0000, 1'b1);
      n_checks++; if (out_valid_s !== 1'b1) $display("FAIL basic_latency out_valid=%b exp=1", out_valid_s); else n_pass++;
      @(negedge clk);
      n_checks++; if (out_valid_s !== 1'b0) $display("FAIL basic_drop out_valid=%b exp=0", out_valid_s); else n_pass++;
   endtask

   task automatic test_pos_overflow();
      push_exp(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0001_0000_0000, 1'b1, 1'b1, 16'd2);
      send_beat(64'h7FFF_FFFF_0000_0000, 1'b0);
      send_beat(64'h0000_0002_0000_0000, 1'b1);
      n_checks++; if (out_valid_s !== 1'b1) $display("FAIL posovf_latency out_valid=%b exp=1", out_valid_s); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_neg_overflow();
      push_exp(64'h8000_0000_0000_0005, 64'h8000_0000_0000_0004, 1'b1, 1'b1, 16'd3);
      send_beat(64'h8000_0000_0000_0000, 1'b0);
      send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      send_beat(64'h0000_0000_0000_0005, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [63:0] held;
      held = 64'h0000_0004_4000_0000;
      out_ready = 1'b0;
      push_exp(held, held, 1'b0, 1'b0, 16'd2);
      send_beat(64'h0000_0004_0000_0000, 1'b0);
      send_beat(64'h0000_0000_4000_0000, 1'b1);
      n_checks++; if (out_valid_s !== 1'b1) $display("FAIL bp_valid got=%b exp=1", out_valid_s); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom};
         in_last  = 1'b1;
         @(negedge clk);
         n_checks++; if (out_data_s !== held) $display("FAIL bp_stable_data got=%h exp=%h", out_data_s, held); else n_pass++;
         n_checks++; if (in_ready_s !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready_s); else n_pass++;
         n_checks++; if (out_cnt_w !== 16'd2) $display("FAIL bp_stable_count got=%0d exp=2", out_cnt_w); else n_pass++;
      end
      in_valid = 1'b0; in_data = 'x; in_last = 1'bx;
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (out_valid_s !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid_s); else n_pass++;
      n_checks++; if (in_ready_s !== 1'b1) $display("FAIL bp_release_in_ready got=%b exp=1", in_ready_s); else n_pass++;
      push_exp(64'h7, 64'h7, 1'b0, 1'b0, 16'd1);
      send_beat(64'h0000_0000_0000_0007, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      push_exp(64'h10, 64'h10, 1'b0, 1'b0, 16'd1);
      send_beat(64'h0000_0000_0000_0010, 1'b1);
      @(negedge clk);
      n_checks++; if (in_ready_s !== 1'b1) $display("FAIL b2b_in_ready got=%b exp=1", in_ready_s); else n_pass++;
      push_exp(64'h23, 64'h23, 1'b0, 1'b0, 16'd2);
      send_beat(64'h0000_0000_0000_0020, 1'b0);
      send_beat(64'h0000_0000_0000_0003, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      // Reset while a result is held: the pending result must vanish.
      out_ready = 1'b0;
      send_beat(64'h0000_0000_0000_0099, 1'b1);
      n_checks++; if (out_valid_s !== 1'b1) $display("FAIL ar_hold_valid got=%b exp=1", out_valid_s); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid_s !== 1'b0) $display("FAIL ar_hold_out_valid got=%b exp=0", out_valid_s); else n_pass++;
      n_checks++; if (out_data_s !== 64'd0) $display("FAIL ar_hold_out_data got=%h exp=0", out_data_s); else n_pass++;
      n_checks++; if (out_cnt_w !== 16'd0) $display("FAIL ar_hold_out_count got=%0d exp=0", out_cnt_w); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      // Reset mid-frame: the partial sum must not leak into the next frame.
      send_beat(64'h0000_0000_0000_0100, 1'b0);
      send_beat(64'h0000_0000_0000_0200, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (in_ready_s !== 1'b0) $display("FAIL ar_frame_in_ready got=%b exp=0", in_ready_s); else n_pass++;
      n_checks++; if (out_ovf_s !== 1'b0) $display("FAIL ar_frame_out_ovf got=%b exp=0", out_ovf_s); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(64'h1, 64'h1, 1'b0, 1'b0, 16'd1);
      send_beat(64'h0000_0000_0000_0001, 1'b1);
      n_checks++; if (out_valid_s !== 1'b1) $display("FAIL ar_new_frame_valid got=%b exp=1", out_valid_s); else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pos_overflow();
      test_neg_overflow();
      test_backpressure();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (sb.size() !== 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size()); else n_pass++;
      n_checks++; if (n_results !== n_pushed) $display("FAIL result_count got=%0d exp=%0d", n_results, n_pushed); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fxp_accumulate_64.md
Name: fxp_accumulate_64

Overview:
- Downstream consumer of the 64-bit fixed-point adder output: accumulates a framed stream of signed Q32.32 operands into a running sum.
- Performs signed overflow detection and optional saturation.
- Emits one result per frame over a valid/ready handshake to the next fixed-point stage (scaler/rounder).

Parameters:
- WIDTH, 64, operand/accumulator width in bits (two's complement).
- FRAC, 32, fractional bits; informational only, no effect on arithmetic.
- CNT_W, 16, width of the per-frame beat counter.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^WIDTH. Overflow is flagged in both modes.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand valid.
- in_ready, output, 1, block can accept an operand.
- in_data, input, WIDTH, signed Q32.32 operand.
- in_last, input, 1, marks the final operand of a frame.
- out_valid, output, 1, frame result valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, WIDTH, accumulated frame sum.
- out_overflow, output, 1, sticky: any overflow occurred within the frame.
- out_count, output, CNT_W, beats accepted in the frame, including the last beat.

Behaviour:
- Reset (async assert, sync release on clk): state=IDLE; acc=0; ovf=0; cnt=0; in_ready=0 while rst_n low; out_valid=0; out_data=0; out_overflow=0; out_count=0.
- States:
  - IDLE: no frame open.
  - ACCUM: frame open.
  - HOLD: result presented.
- in_ready = 1 in IDLE and ACCUM; 0 in HOLD. It is a registered state decode, with no combinational path from out_ready.
- Beat accept = in_valid & in_ready.
- On accept:
  - sum = acc + in_data, computed at full WIDTH.
  - ov = (acc[MSB]==in_data[MSB]) & (sum[MSB]!=acc[MSB]).
  - With SATURATE=1 and ov: result = 0x7FFF_FFFF_FFFF_FFFF when acc is non-negative; otherwise 0x8000_0000_0000_0000.
  - Otherwise result = sum.
  - ovf_next = ovf | ov.
  - cnt_next = cnt+1, saturating at 2^CNT_W-1 (no wrap).
- Transitions:
  - Accept with in_last=0: acc<=result, ovf<=ovf_next, cnt<=cnt_next; state becomes ACCUM (from IDLE or ACCUM).
  - Accept with in_last=1 (IDLE or ACCUM): out_data<=result, out_overflow<=ovf_next, out_count<=cnt_next, out_valid<=1; acc/ovf/cnt cleared to 0; state becomes HOLD.
  - Latency: the result is visible on the cycle after the last-beat accept.
  - A single-beat frame (in_last=1 in IDLE) yields out_data=in_data, out_count=1.
- HOLD:
  - out_data, out_overflow and out_count are stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: out_valid<=0; state becomes IDLE.
  - in_ready rises the following cycle, giving one bubble per frame.
- in_valid in HOLD is ignored; in_data is not sampled.
- Saturated accumulator: subsequent operands continue from the clamped value. Example: 0x7FFF... plus a negative operand decreases normally.
- Reset mid-frame or mid-HOLD: partial sum and pending result are discarded; no out_valid is produced for that frame.
- in_data/in_last are sampled only on accept. X on in_data while in_valid=0 must not propagate.

Test Plan:
- Basic frame: beats 0x0000_0001_0000_0000 (1.0), 0x0000_0002_8000_0000 (2.5), and 0xFFFF_FFFF_8000_0000 (-0.5, last), out_ready=1 -> out_valid one cycle after the last accept; out_data=0x0000_0003_0000_0000; out_count=3; out_overflow=0.
- Positive overflow, SATURATE=1: beats 0x7FFF_FFFF_0000_0000 then 0x0000_0002_0000_0000 (last) -> out_data=0x7FFF_FFFF_FFFF_FFFF; out_overflow=1. With SATURATE=0 -> out_data=0x8000_0001_0000_0000; out_overflow=1.
- Negative overflow with recovery: beats 0x8000_0000_0000_0000, 0xFFFF_FFFF_FFFF_FFFF, then 0x0000_0000_0000_0005 (last), SATURATE=1 -> out_data=0x8000_0000_0000_0005; out_overflow=1 (sticky).
- Backpressure: out_ready held 0 for 5 cycles after the result -> out_data stable; in_ready=0 throughout; in_valid pulses ignored; out_ready=1 -> out_valid drops; in_ready=1 the next cycle; the next frame starts from acc=0.
- Single-beat and back-to-back frames: in_last=1 on the first beat with 0x0000_0000_0000_0010 -> out_count=1; out_data=0x10; a second frame after the handshake is unaffected by the first.
- Async reset mid-frame: two beats accepted, rst_n low asynchronously mid-cycle -> all outputs 0 immediately; after release, a new frame of one beat 0x1 -> out_data=0x1; out_count=1.
